// File: rtl/s_array_reader.sv
// S-array read/check engine: reads all 256 entries once per start and counts entries with s[i] != i.
// Defining S_READER_CHECKSUM_EN adds a modulo-256 checksum output over the data read in the current pass.
module s_array_reader #(
    parameter int READ_LATENCY = 1
) (
    input  logic       clk,
    input  logic       master_reset_n,
    input  logic       start,
    input  logic [7:0] mem_q,
    output logic [7:0] address_out,
    output logic       read_out,
    output logic       done,
    output logic       pass,
    output logic [8:0] err_count,
    output logic [7:0] first_err_addr
`ifdef S_READER_CHECKSUM_EN
    ,
    output logic [7:0] checksum
`endif
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        COMPARE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [1:0] WAIT_LAST = 2'(READ_LATENCY - 1);

    state_t     state_r, state_s;
    logic [7:0] index_r, index_s;
    logic [1:0] wait_r, wait_s;
    logic [8:0] err_r, err_s;
    logic [7:0] first_r, first_s;
    logic       read_r, done_r, pass_r;
`ifdef S_READER_CHECKSUM_EN
    logic [7:0] cks_r, cks_s;
`endif

    // Next-state and next-result computation
    always_comb begin
        state_s = state_r;
        index_s = index_r;
        wait_s  = wait_r;
        err_s   = err_r;
        first_s = first_r;
`ifdef S_READER_CHECKSUM_EN
        cks_s   = cks_r;
`endif
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_s = ISSUE;
                    index_s = 8'd0;
                    err_s   = 9'd0;
                    first_s = 8'd0;
`ifdef S_READER_CHECKSUM_EN
                    cks_s   = 8'd0;
`endif
                end else begin
                    state_s = state_r;
                end
            end
            ISSUE: begin
                state_s = WAIT;
                wait_s  = 2'd0;
            end
            WAIT: begin
                if (wait_r == WAIT_LAST) begin
                    state_s = COMPARE;
                end else begin
                    wait_s = wait_r + 2'd1;
                end
            end
            COMPARE: begin
                if (mem_q != index_r) begin
                    err_s = err_r + 9'd1;
                    if (err_r == 9'd0) begin
                        first_s = index_r;
                    end else begin
                        first_s = first_r;
                    end
                end else begin
                    err_s = err_r;
                end
`ifdef S_READER_CHECKSUM_EN
                cks_s = cks_r + mem_q;
`endif
                // Entry 255 is the last read: the index stays put rather than wrapping to 0
                if (index_r == 8'd255) begin
                    state_s = DONE;
                end else begin
                    state_s = ISSUE;
                    index_s = index_r + 8'd1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, result and registered-output update
    always_ff @(posedge clk or negedge master_reset_n) begin
        if (!master_reset_n) begin
            state_r <= IDLE;
            index_r <= 8'd0;
            wait_r  <= 2'd0;
            err_r   <= 9'd0;
            first_r <= 8'd0;
            read_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
`ifdef S_READER_CHECKSUM_EN
            cks_r   <= 8'd0;
`endif
        end else begin
            state_r <= state_s;
            index_r <= index_s;
            wait_r  <= wait_s;
            err_r   <= err_s;
            first_r <= first_s;
            read_r  <= (state_s == ISSUE);
            done_r  <= (state_s == DONE);
            pass_r  <= (state_s == DONE) && (err_s == 9'd0);
`ifdef S_READER_CHECKSUM_EN
            cks_r   <= cks_s;
`endif
        end
    end

    assign address_out    = index_r;
    assign read_out       = read_r;
    assign done           = done_r;
    assign pass           = pass_r;
    assign err_count      = err_r;
    assign first_err_addr = first_r;
`ifdef S_READER_CHECKSUM_EN
    assign checksum       = cks_r;
`endif

endmodule
